stream_mux_sel: RTL and testbench
=================================

Name: stream_mux_sel

Overview:
Registered 2:1 stream selector feeding the display/output path of the OV7670 background-elimination pipeline. When en=0 it forwards the raw camera byte stream, packed into 16-bit pixels. When en=1 it forwards the 16-bit processed (SA) stream. Valid-only streaming: there is no backpressure and no ready signal.

Parameters:
CAM_W, 8, camera byte-stream data width
OUT_W, 16, SA and output data width; must equal 2*CAM_W

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  source select: 0 = camera stream, 1 = SA stream
tvalid_camera  input  1  camera byte valid
tdata_camera  input  CAM_W  camera byte
tvalid_SA  input  1  SA word valid
tdata_SA  input  OUT_W  SA word
tvalid_out  output  1  output word valid (registered)
tdata_out  output  OUT_W  output word (registered)
byte_pending  output  1  camera high byte captured, low byte awaited

Behaviour:
Clocking and reset
- Single clock domain. Reset is synchronous and active-high.
- During a cycle with rst=1: tvalid_out<=0, tdata_out<=0, byte_pending<=0, internal sel_q<=0, hi_byte<=0. rst overrides all other inputs.

Select tracking
- sel_q <= en every cycle.
- Selection takes effect on the same edge en is sampled. The en→output path is registered, with no extra delay.
- If en differs from sel_q (a switch in either direction), byte_pending is cleared and any captured high byte is discarded.
- No output word is emitted from the discarded byte.

Datapath when en=1 (SA selected)
- tvalid_out <= tvalid_SA.
- If tvalid_SA=1: tdata_out <= tdata_SA. Otherwise tdata_out holds its previous value.
- Latency is 1 cycle.
- Camera inputs are ignored.

Datapath when en=0 (camera selected)
- Camera bytes are paired; the first byte of a pair becomes bits [15:8].
- tvalid_camera=1 and byte_pending=0: hi_byte <= tdata_camera, byte_pending<=1, tvalid_out<=0.
- tvalid_camera=1 and byte_pending=1: tdata_out <= {hi_byte, tdata_camera}, tvalid_out<=1, byte_pending<=0.
- tvalid_camera=0: tvalid_out<=0, tdata_out holds, byte_pending holds. Gaps between the two bytes of a pair are allowed.
- Pixel latency is 1 cycle after the low byte.
- SA inputs are ignored.

General rules
- tvalid_out is a single-cycle pulse per word. It is never asserted for two words from one input beat.
- tdata_out changes only on cycles where tvalid_out<=1 is registered, or on reset.
- Simultaneous events:
  - en switching to 1 in a cycle with tvalid_SA=1 forwards that SA word.
  - en switching to 0 in a cycle with tvalid_camera=1 captures that byte as the high byte. The pending state is cleared first, then the capture is applied.
- Reset mid-pair discards hi_byte.
- No X-propagation requirements beyond reset. en must be driven (not X) from the first post-reset edge.

Decomposition:
- Shared package stream_pkg: CAM_W/OUT_W default constants and a stream_sel_e enum (SEL_CAMERA=0, SEL_SA=1).
- One natural sub-module: byte_packer, containing the hi_byte/byte_pending pairing logic with a flush input driven by the select change.
- Top-level stream_mux_sel holds sel_q, the output mux and the output registers.

Test Plan:
1. rst=1 for 2 cycles with all inputs active → tvalid_out=0, tdata_out=16'h0000, byte_pending=0. Release rst, en=0, no valids → outputs stay 0.
2. en=1, tvalid_SA=1, tdata_SA=16'h00ff → next edge tvalid_out=1, tdata_out=16'h00ff. Drop tvalid_SA=0 → tvalid_out=0, tdata_out holds 16'h00ff.
3. en=1, tdata_SA=16'he0ff, tvalid_SA=1 → tdata_out=16'he0ff. With tvalid_camera=1, tdata_camera=8'he0 toggling meanwhile → no effect, byte_pending=0.
4. en=0, camera bytes 8'he0 then 8'h00 on consecutive valid cycles → first edge byte_pending=1, tvalid_out=0; second edge tvalid_out=1, tdata_out=16'he000. Repeat with a 3-cycle tvalid gap between bytes → same word.
5. en=0, one byte 8'he0 captured (byte_pending=1), then en=1 with tvalid_SA=1, tdata_SA=16'h1234 → byte discarded, tdata_out=16'h1234. Return to en=0 with bytes 8'hab, 8'hcd → 16'habcd (no stale e0).
6. rst asserted while byte_pending=1 → byte_pending=0. Next bytes 8'h11, 8'h22 → tdata_out=16'h1122.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg
// Shared constants and types for the camera/SA output stream selector.
//   STREAM_CAM_W : default camera byte width
//   STREAM_OUT_W : default output / SA word width (two camera bytes)
//   stream_sel_e : source select encoding driven by en
package stream_pkg;

    localparam int STREAM_CAM_W = 8;
    localparam int STREAM_OUT_W = 2 * STREAM_CAM_W;

    typedef enum logic {
        SEL_CAMERA = 1'b0,
        SEL_SA     = 1'b1
    } stream_sel_e;

endpackage

// File: rtl/stream_mux_sel_byte_packer.sv
// byte_packer
// Pairs camera bytes into pixels. The first byte of a pair is held as the
// high byte; the second byte completes the pixel combinationally so the top
// can register it on the same edge.
//   clk, rst    : clock, synchronous active-high reset
//   i_flush     : select changed this cycle; drop any held high byte first
//   i_cam_sel   : camera stream currently selected
//   i_valid     : camera byte valid
//   i_data      : camera byte
//   o_pix_vld   : a complete pixel is available this cycle
//   o_pix       : {held high byte, current byte}
//   o_pending   : high byte held, low byte awaited
module byte_packer #(
    parameter int CAM_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_cam_sel,
    input  logic               i_valid,
    input  logic [CAM_W-1:0]   i_data,
    output logic               o_pix_vld,
    output logic [2*CAM_W-1:0] o_pix,
    output logic               o_pending
);

    logic [CAM_W-1:0] r_hi;
    logic             r_pending;
    logic             w_pend_eff;

    // Flush is applied before this cycle's byte, so a byte arriving on the
    // switch cycle starts a fresh pair instead of completing a stale one.
    assign w_pend_eff = r_pending & ~i_flush;
    assign o_pix_vld  = i_cam_sel & i_valid & w_pend_eff;
    assign o_pix      = {r_hi, i_data};
    assign o_pending  = r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= '0;
            r_pending <= 1'b0;
        end else if (!i_cam_sel) begin
            r_hi      <= '0;
            r_pending <= 1'b0;
        end else if (i_valid) begin
            if (w_pend_eff) begin
                r_pending <= 1'b0;
            end else begin
                r_hi      <= i_data;
                r_pending <= 1'b1;
            end
        end else if (i_flush) begin
            r_hi      <= '0;
            r_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux_sel.sv
// stream_mux_sel
// Registered 2:1 stream selector for the display path. en=0 forwards the
// camera byte stream packed into 16-bit pixels (first byte -> [15:8]);
// en=1 forwards the processed SA word stream. Valid-only, no backpressure.
//   clk, rst       : clock, synchronous active-high reset
//   en             : 0 = camera, 1 = SA; takes effect on the sampling edge
//   tvalid_camera  : camera byte valid
//   tdata_camera   : camera byte
//   tvalid_SA      : SA word valid
//   tdata_SA       : SA word
//   tvalid_out     : registered output valid (one pulse per word)
//   tdata_out      : registered output word; holds between valid words
//   byte_pending   : camera high byte captured, low byte awaited
// OUT_W must equal 2*CAM_W.
module stream_mux_sel
    import stream_pkg::*;
#(
    parameter int CAM_W = STREAM_CAM_W,
    parameter int OUT_W = STREAM_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tvalid_camera,
    input  logic [CAM_W-1:0] tdata_camera,
    input  logic             tvalid_SA,
    input  logic [OUT_W-1:0] tdata_SA,
    output logic             tvalid_out,
    output logic [OUT_W-1:0] tdata_out,
    output logic             byte_pending
);

    stream_sel_e      w_sel;
    logic             r_sel_q;
    logic             w_flush;
    logic             w_pix_vld;
    logic [OUT_W-1:0] w_pix;
    logic             r_tvalid_out;
    logic [OUT_W-1:0] r_tdata_out;

    assign w_sel   = stream_sel_e'(en);
    // Any select change, either direction, drops a half-built pixel.
    assign w_flush = en != r_sel_q;

    byte_packer #(
        .CAM_W (CAM_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_cam_sel (w_sel == SEL_CAMERA),
        .i_valid   (tvalid_camera),
        .i_data    (tdata_camera),
        .o_pix_vld (w_pix_vld),
        .o_pix     (w_pix),
        .o_pending (byte_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q      <= 1'b0;
            r_tvalid_out <= 1'b0;
            r_tdata_out  <= '0;
        end else begin
            r_sel_q <= en;
            if (w_sel == SEL_SA) begin
                r_tvalid_out <= tvalid_SA;
                if (tvalid_SA) r_tdata_out <= tdata_SA;
            end else begin
                r_tvalid_out <= w_pix_vld;
                if (w_pix_vld) r_tdata_out <= w_pix;
            end
        end
    end

    assign tvalid_out = r_tvalid_out;
    assign tdata_out  = r_tdata_out;

endmodule

// File: tb/tb_stream_mux_sel.sv
module tb_stream_mux_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tvalid_camera;
    logic [7:0]  tdata_camera;
    logic        tvalid_SA;
    logic [15:0] tdata_SA;
    logic        tvalid_out;
    logic [15:0] tdata_out;
    logic        byte_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_sel dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .tvalid_camera (tvalid_camera),
        .tdata_camera  (tdata_camera),
        .tvalid_SA     (tvalid_SA),
        .tdata_SA      (tdata_SA),
        .tvalid_out    (tvalid_out),
        .tdata_out     (tdata_out),
        .byte_pending  (byte_pending)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        vc;
        logic [7:0]  dc;
        logic        vs;
        logic [15:0] ds;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic vc, logic [7:0] dc,
                                logic vs, logic [15:0] ds,
                                logic ev, logic [15:0] ed, logic ep);
        vec_t v;
        v.rst = r; v.en = e; v.vc = vc; v.dc = dc; v.vs = vs; v.ds = ds;
        v.e_vld = ev; v.e_data = ed; v.e_pend = ep;
        return v;
    endfunction

    // Apply one cycle of inputs, let one rising edge pass, then compare.
    task automatic step(input string name, input vec_t v);
        rst = v.rst; en = v.en;
        tvalid_camera = v.vc; tdata_camera = v.dc;
        tvalid_SA = v.vs; tdata_SA = v.ds;
        @(posedge clk);
        #1;
        checks++;
        if (tvalid_out !== v.e_vld) begin
            errors++;
            $display("FAIL %s tvalid_out: got %b want %b", name, tvalid_out, v.e_vld);
        end
        checks++;
        if (tdata_out !== v.e_data) begin
            errors++;
            $display("FAIL %s tdata_out: got %h want %h", name, tdata_out, v.e_data);
        end
        checks++;
        if (byte_pending !== v.e_pend) begin
            errors++;
            $display("FAIL %s byte_pending: got %b want %b", name, byte_pending, v.e_pend);
        end
    endtask

    initial begin
        //                rst en vc dc     vs ds        vld data      pend
        // reset with everything active
        vecs.push_back(mk(1, 1, 1, 8'haa, 1, 16'hffff, 0, 16'h0000, 0));
        vecs.push_back(mk(1, 0, 1, 8'h55, 1, 16'hffff, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 16'h0000, 0));
        // SA path, hold on invalid
        vecs.push_back(mk(0, 1, 0, 8'h00, 1, 16'h00ff, 1, 16'h00ff, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 16'h00ff, 0, 16'h00ff, 0));
        // SA path ignores camera activity
        vecs.push_back(mk(0, 1, 1, 8'he0, 1, 16'he0ff, 1, 16'he0ff, 0));
        vecs.push_back(mk(0, 1, 1, 8'h00, 0, 16'h0000, 0, 16'he0ff, 0));
        vecs.push_back(mk(0, 1, 1, 8'he0, 0, 16'h0000, 0, 16'he0ff, 0));
        // switch to camera with a byte on the switch cycle: captured
        vecs.push_back(mk(0, 0, 1, 8'he0, 0, 16'h0000, 0, 16'he0ff, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 16'h0000, 1, 16'he000, 0));
        // pair with a 3-cycle gap
        vecs.push_back(mk(0, 0, 1, 8'he0, 0, 16'h0000, 0, 16'he000, 1));
        vecs.push_back(mk(0, 0, 0, 8'h77, 0, 16'h0000, 0, 16'he000, 1));
        vecs.push_back(mk(0, 0, 0, 8'h77, 1, 16'hbeef, 0, 16'he000, 1));
        vecs.push_back(mk(0, 0, 0, 8'h77, 0, 16'h0000, 0, 16'he000, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 16'h0000, 1, 16'he000, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 16'he000, 0));
        // half pair discarded by switch to SA
        vecs.push_back(mk(0, 0, 1, 8'he0, 0, 16'h0000, 0, 16'he000, 1));
        vecs.push_back(mk(0, 1, 1, 8'h55, 1, 16'h1234, 1, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 1, 8'hab, 0, 16'h0000, 0, 16'h1234, 1));
        vecs.push_back(mk(0, 0, 1, 8'hcd, 0, 16'h0000, 1, 16'habcd, 0));
        // camera selected: SA ignored
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 16'hdead, 0, 16'habcd, 0));

        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

        // Reset mid-pair discards the held byte.
        step("mid_hi",   mk(0, 0, 1, 8'h77, 0, 16'h0000, 0, 16'habcd, 1));
        step("mid_rst",  mk(1, 0, 1, 8'h99, 1, 16'hffff, 0, 16'h0000, 0));
        step("post_hi",  mk(0, 0, 1, 8'h11, 0, 16'h0000, 0, 16'h0000, 1));
        step("post_lo",  mk(0, 0, 1, 8'h22, 0, 16'h0000, 1, 16'h1122, 0));
        step("post_idl", mk(0, 0, 0, 8'h00, 0, 16'h0000, 0, 16'h1122, 0));

        // Switch to SA while pending with no SA word: nothing emitted, data holds.
        step("sw_hi",    mk(0, 0, 1, 8'h3c, 0, 16'h0000, 0, 16'h1122, 1));
        step("sw_sa",    mk(0, 1, 1, 8'h4d, 0, 16'h9999, 0, 16'h1122, 0));
        step("sw_back",  mk(0, 0, 1, 8'h5e, 0, 16'h0000, 0, 16'h1122, 1));
        step("sw_lo",    mk(0, 0, 1, 8'h6f, 0, 16'h0000, 1, 16'h5e6f, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
